// File: rtl/life_gen_sequencer.sv
// Game of Life generation sequencer over a ping-pong pair of cell planes.
// Each cell gathers its 8 neighbours serially, then the Conway rule writes the next plane.
module life_gen_sequencer #(
  parameter int unsigned MAX_I = 19,
  parameter int unsigned MAX_J = 14,
  parameter bit          WRAP  = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        frame_start,
  input  logic        run_en,
  input  logic        step,
  input  logic        wr_en,
  input  logic [4:0]  wr_x,
  input  logic [3:0]  wr_y,
  input  logic        wr_data,
  input  logic [4:0]  rd_x,
  input  logic [3:0]  rd_y,
  output logic        rd_cell,
  output logic        busy,
  output logic        gen_done,
  output logic [15:0] gen_count
);

  localparam int unsigned XW    = 5;
  localparam int unsigned YW    = 4;
  localparam int unsigned NCELL = (MAX_I + 1) * (MAX_J + 1);
  localparam int unsigned CW    = $clog2(NCELL);
  localparam logic [XW-1:0] LAST_X = XW'(MAX_I);
  localparam logic [YW-1:0] LAST_Y = YW'(MAX_J);

  typedef enum logic [1:0] {S_IDLE, S_NBR, S_APPLY, S_SWAP} state_t;

  state_t           state;
  logic [NCELL-1:0] plane [2];
  logic             cur_sel;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [2:0]       k;
  logic [3:0]       sum;

  function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
    return CW'(cy) * CW'(MAX_I + 1) + CW'(cx);
  endfunction

  logic          go_w, go_e, go_n, go_s, off_grid, nbr_bit;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  // Neighbour k (NW,N,NE,W,E,SW,S,SE) coordinates and its current-plane value
  always_comb begin
    go_w = (k == 3'd0) || (k == 3'd3) || (k == 3'd5);
    go_e = (k == 3'd2) || (k == 3'd4) || (k == 3'd7);
    go_n = (k <= 3'd2);
    go_s = (k >= 3'd5);
    nx = x;
    ny = y;
    if (go_w) nx = (x == '0) ? LAST_X : x - XW'(1);
    if (go_e) nx = (x == LAST_X) ? '0 : x + XW'(1);
    if (go_n) ny = (y == '0) ? LAST_Y : y - YW'(1);
    if (go_s) ny = (y == LAST_Y) ? '0 : y + YW'(1);
    off_grid = (go_w && (x == '0)) || (go_e && (x == LAST_X)) ||
               (go_n && (y == '0)) || (go_s && (y == LAST_Y));
    nbr_bit  = plane[cur_sel][cell_idx(nx, ny)] & (WRAP | ~off_grid);
  end

  logic start, cur_cell, next_cell, wr_ok;

  always_comb begin
    start     = step | (run_en & frame_start);
    cur_cell  = plane[cur_sel][cell_idx(x, y)];
    next_cell = (sum == 4'd3) | (cur_cell & (sum == 4'd2));
    wr_ok     = wr_en && (wr_x <= LAST_X) && (wr_y <= LAST_Y);
    rd_cell   = 1'b0;
    if ((rd_x <= LAST_X) && (rd_y <= LAST_Y)) rd_cell = plane[cur_sel][cell_idx(rd_x, rd_y)];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      plane[0]  <= '0;
      plane[1]  <= '0;
      cur_sel   <= 1'b0;
      x         <= '0;
      y         <= '0;
      k         <= '0;
      sum       <= '0;
      busy      <= 1'b0;
      gen_done  <= 1'b0;
      gen_count <= '0;
    end else begin
      gen_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Seed write lands before the first neighbour read of a same-cycle start
          if (wr_ok) plane[cur_sel][cell_idx(wr_x, wr_y)] <= wr_data;
          if (start) begin
            x     <= '0;
            y     <= '0;
            k     <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= S_NBR;
          end
        end
        S_NBR: begin
          sum <= sum + 4'(nbr_bit);
          k   <= k + 3'd1;
          if (k == 3'd7) state <= S_APPLY;
        end
        S_APPLY: begin
          plane[~cur_sel][cell_idx(x, y)] <= next_cell;
          sum <= '0;
          k   <= '0;
          if (x != LAST_X) begin
            x     <= x + XW'(1);
            state <= S_NBR;
          end else begin
            x <= '0;
            if (y != LAST_Y) begin
              y     <= y + YW'(1);
              state <= S_NBR;
            end else begin
              state <= S_SWAP;
            end
          end
        end
        S_SWAP: begin
          cur_sel   <= ~cur_sel;
          gen_count <= gen_count + 16'd1;
          busy      <= 1'b0;
          gen_done  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: bounded-grid and toroidal instances share stimulus
// and are compared against a direct Game of Life model.
module tb_life_gen_sequencer;

  logic        clk = 1'b0;
  logic        clr, frame_start, run_en, step, wr_en, wr_data;
  logic [4:0]  wr_x, rd_x;
  logic [3:0]  wr_y, rd_y;
  logic        rd_cell0, busy0, done0, rd_cell1, busy1, done1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  life_gen_sequencer #(.MAX_I(19), .MAX_J(14), .WRAP(1'b0)) dut (
    .clk(clk), .clr(clr), .frame_start(frame_start), .run_en(run_en), .step(step),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y),
    .rd_cell(rd_cell0), .busy(busy0), .gen_done(done0), .gen_count(cnt0));

  life_gen_sequencer #(.MAX_I(19), .MAX_J(14), .WRAP(1'b1)) dut_w (
    .clk(clk), .clr(clr), .frame_start(frame_start), .run_en(run_en), .step(step),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y),
    .rd_cell(rd_cell1), .busy(busy1), .gen_done(done1), .gen_count(cnt1));

  int checks = 0;
  int failures = 0;
  logic [299:0] m0, m1;

  typedef struct {
    string name;
    int    n;
    int    sx[4];
    int    sy[4];
    int    en;
    int    ex[4];
    int    ey[4];
  } vec_t;

  vec_t vecs[3];

  function automatic logic [299:0] life_next(input logic [299:0] g, input bit wrap);
    logic [299:0] r;
    int n, xx, yy;
    r = '0;
    for (int y = 0; y < 15; y++) begin
      for (int x = 0; x < 20; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            xx = x + dx;
            yy = y + dy;
            if (wrap) begin
              xx = (xx + 20) % 20;
              yy = (yy + 15) % 15;
            end
            if (xx >= 0 && xx < 20 && yy >= 0 && yy < 15) n += int'(g[yy*20+xx]);
          end
        end
        r[y*20+x] = (n == 3) || (g[y*20+x] && n == 2);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_grid(input string name, input logic [299:0] e0, input logic [299:0] e1);
    int err0, err1, b0, b1;
    err0 = 0;
    err1 = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 32; x++) begin
        rd_x = 5'(x);
        rd_y = 4'(y);
        #1;
        b0 = (x < 20 && y < 15) ? int'(e0[y*20+x]) : 0;
        b1 = (x < 20 && y < 15) ? int'(e1[y*20+x]) : 0;
        if (int'(rd_cell0) != b0) err0++;
        if (int'(rd_cell1) != b1) err1++;
      end
    end
    chk({name, "_grid_bounded_errs"}, err0, 0);
    chk({name, "_grid_wrap_errs"}, err1, 0);
  endtask

  task automatic wr_cell(input int x, input int y, input bit v);
    wr_en = 1'b1;
    wr_x = 5'(x);
    wr_y = 4'(y);
    wr_data = v;
    tick();
    wr_en = 1'b0;
    if (x < 20 && y < 15) begin
      m0[y*20+x] = v;
      m1[y*20+x] = v;
    end
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #2;
    clr = 1'b1;
    m0 = '0;
    m1 = '0;
    tick();
  endtask

  // Start a generation, optionally disturb it mid-run, and check latency and done pulse
  task automatic run_gen(input string name, input bit s, input bit f, input bit disturb);
    int cyc;
    step = s;
    frame_start = f;
    tick();
    cyc = 1;
    step = 1'b0;
    frame_start = 1'b0;
    wr_en = 1'b0;
    chk({name, "_busy"}, int'(busy0), 1);
    while (!done0 && cyc < 3000) begin
      if (disturb && cyc == 100) begin
        step = 1'b1;
        frame_start = 1'b1;
        wr_en = 1'b1;
        wr_x = 5'd10;
        wr_y = 4'd10;
        wr_data = 1'b1;
      end
      tick();
      cyc++;
      step = 1'b0;
      frame_start = 1'b0;
      wr_en = 1'b0;
    end
    chk({name, "_latency"}, cyc, 2702);
    chk({name, "_done_wrap"}, int'(done1), 1);
    chk({name, "_busy_end"}, int'(busy0), 0);
    m0 = life_next(m0, 1'b0);
    m1 = life_next(m1, 1'b1);
    tick();
    chk({name, "_done_pulse"}, int'(done0), 0);
  endtask

  initial begin
    logic [299:0] e;
    clr = 1'b0; frame_start = 1'b0; run_en = 1'b0; step = 1'b0;
    wr_en = 1'b0; wr_data = 1'b0; wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0;
    m0 = '0;
    m1 = '0;

    vecs[0].name = "blinker"; vecs[0].n = 3;
    vecs[0].sx = '{5, 6, 7, 0}; vecs[0].sy = '{4, 4, 4, 0};
    vecs[0].en = 3; vecs[0].ex = '{6, 6, 6, 0}; vecs[0].ey = '{3, 4, 5, 0};
    vecs[1].name = "block"; vecs[1].n = 4;
    vecs[1].sx = '{2, 3, 2, 3}; vecs[1].sy = '{2, 2, 3, 3};
    vecs[1].en = 4; vecs[1].ex = '{2, 3, 2, 3}; vecs[1].ey = '{2, 2, 3, 3};
    vecs[2].name = "edges"; vecs[2].n = 3;
    vecs[2].sx = '{0, 19, 0, 0}; vecs[2].sy = '{0, 0, 14, 0};
    vecs[2].en = 0; vecs[2].ex = '{0, 0, 0, 0}; vecs[2].ey = '{0, 0, 0, 0};

    #12;
    chk("reset_busy", int'(busy0), 0);
    chk("reset_done", int'(done0), 0);
    chk("reset_count", int'(cnt0), 0);
    compare_grid("reset", m0, m1);
    clr = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].n; j++) wr_cell(vecs[i].sx[j], vecs[i].sy[j], 1'b1);
      run_gen(vecs[i].name, 1'b1, 1'b0, 1'b0);
      chk({vecs[i].name, "_count"}, int'(cnt0), 1);
      e = '0;
      for (int j = 0; j < vecs[i].en; j++) e[vecs[i].ey[j]*20 + vecs[i].ex[j]] = 1'b1;
      compare_grid(vecs[i].name, e, m1);
      m0 = e;
      if (vecs[i].name == "edges") begin
        rd_x = 5'd0; rd_y = 4'd0; #1;
        chk("edges_wrap_corner_survives", int'(rd_cell1), 1);
        rd_x = 5'd19; rd_y = 4'd14; #1;
        chk("edges_wrap_far_corner_born", int'(rd_cell1), 1);
      end
    end

    // Blinker period 2
    do_reset();
    wr_cell(5, 4, 1'b1); wr_cell(6, 4, 1'b1); wr_cell(7, 4, 1'b1);
    e = m0;
    run_gen("blink1", 1'b1, 1'b0, 1'b0);
    run_gen("blink2", 1'b1, 1'b0, 1'b0);
    chk("blink2_count", int'(cnt0), 2);
    compare_grid("blink2", e, e);

    // Block under free-run with frame_start
    do_reset();
    wr_cell(2, 2, 1'b1); wr_cell(3, 2, 1'b1); wr_cell(2, 3, 1'b1); wr_cell(3, 3, 1'b1);
    e = m0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("frame_no_run_idle", int'(busy0), 0);
    run_en = 1'b1;
    for (int i = 0; i < 4; i++) run_gen("block_run", 1'b0, 1'b1, 1'b0);
    chk("block_run_count", int'(cnt0), 4);
    compare_grid("block_run", e, m1);

    // step+frame_start together, then step/wr_en while busy
    run_gen("collide", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("collide_count", int'(cnt0), 5);
    chk("collide_idle", int'(busy0), 0);
    compare_grid("collide", m0, m1);
    run_en = 1'b0;

    // Seed write in the same cycle as the start
    do_reset();
    wr_cell(5, 4, 1'b1); wr_cell(6, 4, 1'b1); wr_cell(7, 4, 1'b1);
    wr_en = 1'b1; wr_x = 5'd6; wr_y = 4'd5; wr_data = 1'b1;
    m0[5*20+6] = 1'b1;
    m1[5*20+6] = 1'b1;
    run_gen("wr_start", 1'b1, 1'b0, 1'b0);
    compare_grid("wr_start", m0, m1);

    // Reset in the middle of a generation
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    clr = 1'b0;
    #1;
    chk("midreset_busy", int'(busy0), 0);
    chk("midreset_count", int'(cnt0), 0);
    m0 = '0;
    m1 = '0;
    compare_grid("midreset", m0, m1);
    clr = 1'b1;
    tick();
    wr_cell(5, 4, 1'b1); wr_cell(6, 4, 1'b1); wr_cell(7, 4, 1'b1);
    run_gen("after_reset", 1'b1, 1'b0, 1'b0);
    chk("after_reset_count", int'(cnt0), 1);
    compare_grid("after_reset", m0, m1);

    // Random soups, including out-of-range writes
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 200; i++)
        wr_cell(int'($urandom_range(31, 0)), int'($urandom_range(15, 0)), 1'($urandom));
      compare_grid("rand_seed", m0, m1);
      run_gen("rand_g1", 1'b1, 1'b0, 1'b0);
      compare_grid("rand_g1", m0, m1);
      run_gen("rand_g2", 1'b1, 1'b0, 1'b0);
      compare_grid("rand_g2", m0, m1);
      chk("rand_count", int'(cnt1), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
